// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sram_pkg
// Brief    : Shared types and helpers for the multi-bank SRAM array.
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Widest word the byte-merge helper handles; callers size-cast in and out.
    localparam int MAX_WIDTH = 1024;
    localparam int MAX_BE    = MAX_WIDTH / 8;

    function automatic int bank_w(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] be_merge(
        input logic [MAX_WIDTH-1:0] old_word,
        input logic [MAX_WIDTH-1:0] new_word,
        input logic [MAX_BE-1:0]    be
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bank_array_if.sv
`default_nettype none
// ============================================================================
// Interface : sram_bank_array_if
// Brief     : Request/response bus of the multi-bank SRAM array.
// Revision  : 1.0 - initial release
// ============================================================================
interface sram_bank_array_if
    import sram_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2048,
    parameter int BANKS = 4
);
    localparam int BW = bank_w(BANKS);
    localparam int AW = addr_w(DEPTH);

    logic             ready;
    logic             req_valid;
    logic             req_we;
    logic [BW-1:0]    req_bank;
    logic [AW-1:0]    req_addr;
    logic [WIDTH/8-1:0] req_be;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic [BW-1:0]    rsp_bank;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        input  ready, rsp_valid, rsp_bank, rsp_data,
        output req_valid, req_we, req_bank, req_addr, req_be, req_wdata
    );

    modport slave (
        output ready, rsp_valid, rsp_bank, rsp_data,
        input  req_valid, req_we, req_bank, req_addr, req_be, req_wdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_bank.sv
`default_nettype none
// ============================================================================
// Module   : sram_bank
// Brief    : One DEPTH x WIDTH bank, byte-enable write, registered read-first.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bank
    import sram_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH/8-1:0]       be,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rd_data_q
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] merged;

    always_comb begin
        merged    = WIDTH'(be_merge(MAX_WIDTH'(mem[addr]), MAX_WIDTH'(wdata), MAX_BE'(be)));
        rd_data_d = re ? mem[addr] : rd_data_q;
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end
endmodule
`default_nettype wire

// File: rtl/sram_bank_array.sv
`default_nettype none
// ============================================================================
// Module   : sram_bank_array
// Brief    : BANKS-way SRAM with zero-fill after reset and RD_LAT read pipe.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bank_array
    import sram_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 2048,
    parameter int BANKS   = 4,
    parameter int RD_LAT  = 2,
    parameter int INIT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    sram_bank_array_if.slave bus
);
    localparam int BW  = bank_w(BANKS);
    localparam int AW  = addr_w(DEPTH);
    localparam int BEW = WIDTH / 8;

    if ((WIDTH % 8) != 0 || WIDTH > MAX_WIDTH) begin : g_chk_width
        $error("sram_bank_array: WIDTH must be a multiple of 8 and <= MAX_WIDTH");
    end
    if (DEPTH < 2 || BANKS < 1 || RD_LAT < 1) begin : g_chk_sizes
        $error("sram_bank_array: DEPTH>=2, BANKS>=1, RD_LAT>=1 required");
    end

    state_t           state_q, state_d;
    logic [AW-1:0]    fill_ptr_q, fill_ptr_d;
    logic             s1_valid_q, s1_valid_d;
    logic [BW-1:0]    s1_bank_q, s1_bank_d;
    logic [WIDTH-1:0] s1_data;
    logic             fill, ready, req_ok;
    logic [AW-1:0]    bank_addr;
    logic [BEW-1:0]   bank_be;
    logic [WIDTH-1:0] bank_wdata;
    logic [BANKS-1:0] bank_we, bank_re;
    logic [WIDTH-1:0] bank_rdata [BANKS];
    logic             rsp_valid;
    logic [BW-1:0]    rsp_bank;
    logic [WIDTH-1:0] rsp_data;

    // Reset always lands in INIT so ready stays low until the first edge.
    always_comb begin
        state_d    = state_q;
        fill_ptr_d = fill_ptr_q;
        fill       = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (INIT_EN != 0) begin
                    fill       = 1'b1;
                    fill_ptr_d = fill_ptr_q + 1'b1;
                    if (fill_ptr_q == AW'(DEPTH - 1)) begin
                        state_d    = ST_READY;
                        fill_ptr_d = '0;
                    end
                end else begin
                    state_d = ST_READY;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready      = (state_q == ST_READY);
        req_ok     = bus.req_valid && ready && (int'(bus.req_bank) < BANKS)
                     && (int'(bus.req_addr) < DEPTH);
        bank_addr  = fill ? fill_ptr_q : bus.req_addr;
        bank_be    = fill ? '1 : bus.req_be;
        bank_wdata = fill ? '0 : bus.req_wdata;
        for (int b = 0; b < BANKS; b++) begin
            bank_we[b] = fill || (req_ok && bus.req_we && (int'(bus.req_bank) == b));
            bank_re[b] = req_ok && !bus.req_we && (int'(bus.req_bank) == b);
        end
        s1_valid_d = req_ok && !bus.req_we;
        s1_bank_d  = s1_valid_d ? bus.req_bank : s1_bank_q;
        s1_data    = bank_rdata[s1_bank_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            fill_ptr_q <= '0;
            s1_valid_q <= 1'b0;
            s1_bank_q  <= '0;
        end else begin
            state_q    <= state_d;
            fill_ptr_q <= fill_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_bank_q  <= s1_bank_d;
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        sram_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .we        (bank_we[g]),
            .re        (bank_re[g]),
            .addr      (bank_addr),
            .be        (bank_be),
            .wdata     (bank_wdata),
            .rd_data_q (bank_rdata[g])
        );
    end

    if (RD_LAT == 1) begin : g_lat1
        assign rsp_valid = s1_valid_q;
        assign rsp_bank  = s1_bank_q;
        assign rsp_data  = s1_data;
    end else begin : g_latn
        localparam int N = RD_LAT - 1;
        logic [N-1:0]     pv_q, pv_d;
        logic [BW-1:0]    pb_q [N];
        logic [BW-1:0]    pb_d [N];
        logic [WIDTH-1:0] pd_q [N];
        logic [WIDTH-1:0] pd_d [N];

        // Bank/data stages only advance with a valid so rsp_data holds when idle.
        always_comb begin
            pv_d[0] = s1_valid_q;
            pb_d[0] = s1_valid_q ? s1_bank_q : pb_q[0];
            pd_d[0] = s1_valid_q ? s1_data : pd_q[0];
            for (int i = 1; i < N; i++) begin
                pv_d[i] = pv_q[i-1];
                pb_d[i] = pv_q[i-1] ? pb_q[i-1] : pb_q[i];
                pd_d[i] = pv_q[i-1] ? pd_q[i-1] : pd_q[i];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pv_q <= '0;
                for (int i = 0; i < N; i++) begin
                    pb_q[i] <= '0;
                    pd_q[i] <= '0;
                end
            end else begin
                pv_q <= pv_d;
                for (int i = 0; i < N; i++) begin
                    pb_q[i] <= pb_d[i];
                    pd_q[i] <= pd_d[i];
                end
            end
        end

        assign rsp_valid = pv_q[N-1];
        assign rsp_bank  = pb_q[N-1];
        assign rsp_data  = pd_q[N-1];
    end

    assign bus.ready     = ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_bank  = rsp_bank;
    assign bus.rsp_data  = rsp_data;
endmodule
`default_nettype wire

// File: tb/tb_sram_bank_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bank_array
// Brief    : Scoreboard bench: DUT A (RD_LAT=2, fill on) and DUT B (RD_LAT=1, no fill).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bank_array;
    localparam int W  = 32;
    localparam int D  = 16;
    localparam int NB = 4;

    typedef struct {
        logic [1:0]  bank;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_na = 1'b0;
    logic rst_nb = 1'b0;
    always #5 clk = ~clk;

    sram_bank_array_if #(.WIDTH(W), .DEPTH(D), .BANKS(NB)) ifa ();
    sram_bank_array_if #(.WIDTH(W), .DEPTH(D), .BANKS(NB)) ifb ();

    sram_bank_array #(.WIDTH(W), .DEPTH(D), .BANKS(NB), .RD_LAT(2), .INIT_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_na), .bus(ifa)
    );
    sram_bank_array #(.WIDTH(W), .DEPTH(D), .BANKS(NB), .RD_LAT(1), .INIT_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_nb), .bus(ifb)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit rdy_a  = 0;
    bit rdy_b  = 0;
    logic [31:0] ma [NB][D];
    logic [31:0] mb [NB][D];
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one cycle of request on DUT A (sel_b=0) or DUT B (sel_b=1) and predict.
    task automatic op(input bit sel_b, input logic v, input logic we, input int b, input int a,
                      input logic [3:0] be, input logic [31:0] d);
        if (!sel_b) begin
            ifa.req_valid = v; ifa.req_we = we; ifa.req_bank = 2'(b);
            ifa.req_addr = 4'(a); ifa.req_be = be; ifa.req_wdata = d;
        end else begin
            ifb.req_valid = v; ifb.req_we = we; ifb.req_bank = 2'(b);
            ifb.req_addr = 4'(a); ifb.req_be = be; ifb.req_wdata = d;
        end
        if (v && (sel_b ? rdy_b : rdy_a)) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        if (sel_b) mb[b][a][8*i +: 8] = d[8*i +: 8];
                        else       ma[b][a][8*i +: 8] = d[8*i +: 8];
                    end
                end
            end else if (sel_b) begin
                qb.push_back('{2'(b), mb[b][a], cyc + 1});
            end else begin
                qa.push_back('{2'(b), ma[b][a], cyc + 2});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit sel_b, input int n);
        for (int i = 0; i < n; i++) op(sel_b, 1'b0, 1'b0, 0, 0, 4'h0, 32'h0);
    endtask

    // Release A's reset while hammering writes; fill must take exactly D cycles.
    task automatic release_a();
        rst_na = 1'b1;
        for (int k = 0; k < D; k++) begin
            chk("a_init_ready_low", 32'(ifa.ready), 32'd0);
            op(0, 1'b1, 1'b1, int'($urandom_range(0, NB-1)), int'($urandom_range(0, D-1)),
               4'hF, 32'hFFFF_FFFF);
        end
        chk("a_ready_after_fill", 32'(ifa.ready), 32'd1);
        rdy_a = 1;
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < D; a++) ma[b][a] = 32'h0;
    endtask

    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].due < cyc) begin
            ea = qa.pop_front();
            checks++; errors++;
            $display("FAIL a_rsp_missing bank=%0d data=%h due=%0d", ea.bank, ea.data, ea.due);
        end
        checks++;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            ea = qa.pop_front();
            if (ifa.rsp_valid !== 1'b1 || ifa.rsp_bank !== ea.bank || ifa.rsp_data !== ea.data) begin
                errors++;
                $display("FAIL a_rsp actual valid=%b bank=%0d data=%h required valid=1 bank=%0d data=%h",
                         ifa.rsp_valid, ifa.rsp_bank, ifa.rsp_data, ea.bank, ea.data);
            end
        end else if (ifa.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL a_rsp_spurious actual valid=%b bank=%0d data=%h required valid=0",
                     ifa.rsp_valid, ifa.rsp_bank, ifa.rsp_data);
        end
    end

    always @(negedge clk) begin
        while (qb.size() > 0 && qb[0].due < cyc) begin
            eb = qb.pop_front();
            checks++; errors++;
            $display("FAIL b_rsp_missing bank=%0d data=%h due=%0d", eb.bank, eb.data, eb.due);
        end
        checks++;
        if (qb.size() > 0 && qb[0].due == cyc) begin
            eb = qb.pop_front();
            if (ifb.rsp_valid !== 1'b1 || ifb.rsp_bank !== eb.bank || ifb.rsp_data !== eb.data) begin
                errors++;
                $display("FAIL b_rsp actual valid=%b bank=%0d data=%h required valid=1 bank=%0d data=%h",
                         ifb.rsp_valid, ifb.rsp_bank, ifb.rsp_data, eb.bank, eb.data);
            end
        end else if (ifb.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b_rsp_spurious actual valid=%b bank=%0d data=%h required valid=0",
                     ifb.rsp_valid, ifb.rsp_bank, ifb.rsp_data);
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_bank = '0;
        ifa.req_addr = '0; ifa.req_be = '0; ifa.req_wdata = '0;
        ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_bank = '0;
        ifb.req_addr = '0; ifb.req_be = '0; ifb.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("a_reset_ready", 32'(ifa.ready), 32'd0);
        chk("a_reset_rsp_bank", 32'(ifa.rsp_bank), 32'd0);
        chk("a_reset_rsp_data", ifa.rsp_data, 32'd0);
        chk("b_reset_ready", 32'(ifb.ready), 32'd0);

        release_a();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < D; a++) op(0, 1'b1, 1'b0, b, a, 4'h0, 32'h0);
        idle(0, 2);

        op(0, 1'b1, 1'b1, 2, 5, 4'hF, 32'h1122_3344);
        op(0, 1'b1, 1'b1, 2, 5, 4'h5, 32'hAABB_CCDD);
        op(0, 1'b1, 1'b0, 2, 5, 4'h0, 32'h0);
        idle(0, 3);

        for (int b = 0; b < NB; b++) op(0, 1'b1, 1'b1, b, 3, 4'hF, 32'hCAFE_F00D);
        idle(0, 1);
        for (int b = 0; b < NB; b++) op(0, 1'b1, 1'b0, b, 3, 4'h0, 32'h0);
        idle(0, 3);

        op(0, 1'b1, 1'b1, 1, 7, 4'hF, 32'h1234_5678);
        op(0, 1'b1, 1'b0, 1, 7, 4'h0, 32'h0);
        op(0, 1'b1, 1'b0, 0, 7, 4'h0, 32'h0);
        op(0, 1'b1, 1'b1, 1, 7, 4'h0, 32'hDEAD_BEEF);
        op(0, 1'b1, 1'b0, 1, 7, 4'h0, 32'h0);
        idle(0, 3);

        for (int n = 0; n < 400; n++)
            op(0, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, NB-1)), int'($urandom_range(0, D-1)),
               4'($urandom), $urandom);
        idle(0, 4);

        // A read in flight when reset hits must never respond.
        op(0, 1'b1, 1'b0, 2, 5, 4'h0, 32'h0);
        rst_na = 1'b0; rdy_a = 0; qa.delete();
        idle(0, 2);
        chk("a_rst_ready", 32'(ifa.ready), 32'd0);
        rst_na = 1'b1;
        for (int k = 0; k < 7; k++) op(0, 1'b1, 1'b1, 0, k, 4'hF, 32'hFFFF_FFFF);
        rst_na = 1'b0;
        idle(0, 2);
        chk("a_midinit_rst_ready", 32'(ifa.ready), 32'd0);
        release_a();
        for (int n = 0; n < 24; n++)
            op(0, 1'b1, 1'b0, int'($urandom_range(0, NB-1)), int'($urandom_range(0, D-1)), 4'h0, 32'h0);
        idle(0, 4);

        rst_nb = 1'b1;
        chk("b_ready_before_edge", 32'(ifb.ready), 32'd0);
        idle(1, 1);
        chk("b_ready_first_edge", 32'(ifb.ready), 32'd1);
        rdy_b = 1;
        op(1, 1'b1, 1'b1, 3, 15, 4'hF, 32'h0000_BEEF);
        op(1, 1'b1, 1'b0, 3, 15, 4'h0, 32'h0);
        idle(1, 2);
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < D; a++) op(1, 1'b1, 1'b1, b, a, 4'hF, $urandom);
        for (int n = 0; n < 150; n++)
            op(1, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, NB-1)), int'($urandom_range(0, D-1)),
               4'($urandom), $urandom);
        idle(1, 4);

        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
